// File: rtl/envelope_vca_pkg.sv
// Shared audio definitions for the per-voice amplitude stage: envelope
// state encoding and default sample width.
package envelope_vca_pkg;

    typedef enum logic [2:0] {
        ENV_IDLE    = 3'd0,
        ENV_ATTACK  = 3'd1,
        ENV_DECAY   = 3'd2,
        ENV_SUSTAIN = 3'd3,
        ENV_RELEASE = 3'd4
    } env_state_t;

    localparam int AUDIO_BITDEPTH = 14;
    localparam logic [AUDIO_BITDEPTH-1:0] AUDIO_MIDPOINT =
        {1'b1, {(AUDIO_BITDEPTH-1){1'b0}}};

endpackage

// File: rtl/envelope_vca_vca_mult.sv
// Two-stage VCA: re-centre the unsigned oscillator sample, then scale it by
// an 8-bit gain as a fraction of 256 (no rounding).
module vca_mult
    import envelope_vca_pkg::*;
#(
    parameter int BITDEPTH = AUDIO_BITDEPTH
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [BITDEPTH-1:0] i_osc,
    input  logic [7:0]          i_gain,
    output logic [BITDEPTH-1:0] o_audio
);

    localparam logic [BITDEPTH-1:0] MIDPOINT = {1'b1, {(BITDEPTH-1){1'b0}}};

    logic signed [BITDEPTH-1:0] r_c;
    logic        [7:0]          r_g;
    logic signed [BITDEPTH+7:0] w_prod;
    logic                       w_unused_frac;

    // Gain is zero-extended so the product stays signed; BITDEPTH+8 bits
    // holds the worst case of -2^(BITDEPTH-1) * 255.
    assign w_prod = $signed({{8{r_c[BITDEPTH-1]}}, r_c}) *
                    $signed({{BITDEPTH{1'b0}}, r_g});
    assign w_unused_frac = ^w_prod[7:0];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_c     <= '0;
            r_g     <= '0;
            o_audio <= '0;
        end else begin
            r_c     <= $signed(i_osc - MIDPOINT);
            r_g     <= i_gain;
            o_audio <= w_prod[BITDEPTH+7:8];
        end
    end

endmodule

// File: rtl/envelope_vca.sv
// Per-voice ADSR envelope generator driving a pipelined VCA; one envelope
// step and one output sample per sample_clock edge.
module envelope_vca
    import envelope_vca_pkg::*;
#(
    parameter int BITDEPTH = AUDIO_BITDEPTH,
    parameter int ENV_W    = 16
) (
    input  logic                sample_clock,
    input  logic                rst_n,
    input  logic                gate,
    input  logic [7:0]          attack_rate,
    input  logic [7:0]          decay_rate,
    input  logic [7:0]          sustain_level,
    input  logic [7:0]          release_rate,
    input  logic [BITDEPTH-1:0] osc_in,
    output logic [BITDEPTH-1:0] audio_out,
    output logic [7:0]          env_level,
    output logic                active
);

    localparam logic [ENV_W:0] ENV_MAX_X = {1'b0, {ENV_W{1'b1}}};

    env_state_t       r_state;
    env_state_t       w_state_next;
    logic [ENV_W-1:0] r_env;
    logic [ENV_W-1:0] w_env_next;
    logic             r_gate_d;
    logic             w_rise;
    logic [ENV_W-1:0] w_target;
    logic [ENV_W-1:0] w_rel_rate;
    logic [ENV_W:0]   w_sum;
    logic [ENV_W:0]   w_dec;

    assign w_rise     = gate & ~r_gate_d;
    assign w_target   = {sustain_level, {(ENV_W-8){1'b0}}};
    assign w_rel_rate = {{(ENV_W-8){1'b0}}, release_rate};
    assign w_sum      = {1'b0, r_env} + {{(ENV_W-7){1'b0}}, attack_rate};
    assign w_dec      = {1'b0, r_env} - {{(ENV_W-7){1'b0}}, decay_rate};

    always_ff @(posedge sample_clock or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ENV_IDLE;
            r_env    <= '0;
            r_gate_d <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_env    <= w_env_next;
            r_gate_d <= gate;
        end
    end

    // Retrigger keeps the current level; gate-off applies the release step
    // on the same clock it is seen.
    always_comb begin
        w_state_next = r_state;
        w_env_next   = r_env;
        if (w_rise) begin
            w_state_next = ENV_ATTACK;
        end else if (r_state == ENV_RELEASE || (!gate && r_state != ENV_IDLE)) begin
            if (r_env <= w_rel_rate) begin
                w_env_next   = '0;
                w_state_next = ENV_IDLE;
            end else begin
                w_env_next   = r_env - w_rel_rate;
                w_state_next = ENV_RELEASE;
            end
        end else begin
            case (r_state)
                ENV_IDLE: w_env_next = '0;
                ENV_ATTACK: begin
                    if (w_sum >= ENV_MAX_X) begin
                        w_env_next   = ENV_MAX_X[ENV_W-1:0];
                        w_state_next = ENV_DECAY;
                    end else begin
                        w_env_next = w_sum[ENV_W-1:0];
                    end
                end
                ENV_DECAY: begin
                    if ($signed(w_dec) <= $signed({1'b0, w_target})) begin
                        w_env_next   = w_target;
                        w_state_next = ENV_SUSTAIN;
                    end else begin
                        w_env_next = w_dec[ENV_W-1:0];
                    end
                end
                ENV_SUSTAIN: w_env_next = w_target;
                default: begin
                    w_env_next   = '0;
                    w_state_next = ENV_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        env_level = r_env[ENV_W-1 -: 8];
        active    = (r_state != ENV_IDLE);
    end

    vca_mult #(
        .BITDEPTH(BITDEPTH)
    ) u_vca (
        .i_clk  (sample_clock),
        .i_rst_n(rst_n),
        .i_osc  (osc_in),
        .i_gain (env_level),
        .o_audio(audio_out)
    );

endmodule

// File: tb/tb_envelope_vca.sv
// Self-checking bench for envelope_vca: directed ADSR/VCA scenarios plus
// randomized stimulus against an arithmetic reference model.
module tb_envelope_vca;

    localparam int PH_IDLE = 0;
    localparam int PH_ATK  = 1;
    localparam int PH_DEC  = 2;
    localparam int PH_SUS  = 3;
    localparam int PH_REL  = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        gate = 1'b0;
    logic [7:0]  attack_rate = '0;
    logic [7:0]  decay_rate = '0;
    logic [7:0]  sustain_level = '0;
    logic [7:0]  release_rate = '0;
    logic [13:0] osc_in = '0;
    logic [13:0] audio_out;
    logic [7:0]  env_level;
    logic        active;

    int checks = 0;
    int failures = 0;

    int m_env = 0;
    int m_phase = PH_IDLE;
    int m_gd = 0;
    int m_c1 = 0;
    int m_g1 = 0;
    int m_out = 0;

    envelope_vca #(
        .BITDEPTH(14),
        .ENV_W(16)
    ) dut (
        .sample_clock (clk),
        .rst_n        (rst_n),
        .gate         (gate),
        .attack_rate  (attack_rate),
        .decay_rate   (decay_rate),
        .sustain_level(sustain_level),
        .release_rate (release_rate),
        .osc_in       (osc_in),
        .audio_out    (audio_out),
        .env_level    (env_level),
        .active       (active)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_env = 0; m_phase = PH_IDLE; m_gd = 0;
        m_c1 = 0; m_g1 = 0; m_out = 0;
    endtask

    // Advance one sample clock and the reference model; leaves time at edge+1.
    task automatic tick();
        int target;
        bit rise;
        @(posedge clk);
        if (rst_n) begin
            m_out = ((m_c1 * m_g1) >>> 8) & 'h3FFF;
            m_c1  = int'(osc_in) - 8192;
            m_g1  = m_env / 256;
            target = int'(sustain_level) * 256;
            rise = gate && (m_gd == 0);
            if (rise) begin
                m_phase = PH_ATK;
            end else if (m_phase == PH_REL || (!gate && m_phase != PH_IDLE)) begin
                if (m_env <= int'(release_rate)) begin
                    m_env = 0; m_phase = PH_IDLE;
                end else begin
                    m_env = m_env - int'(release_rate); m_phase = PH_REL;
                end
            end else if (m_phase == PH_IDLE) begin
                m_env = 0;
            end else if (m_phase == PH_ATK) begin
                if (m_env + int'(attack_rate) >= 65535) begin
                    m_env = 65535; m_phase = PH_DEC;
                end else begin
                    m_env = m_env + int'(attack_rate);
                end
            end else if (m_phase == PH_DEC) begin
                if (m_env - int'(decay_rate) <= target) begin
                    m_env = target; m_phase = PH_SUS;
                end else begin
                    m_env = m_env - int'(decay_rate);
                end
            end else begin
                m_env = target;
            end
            m_gd = gate ? 1 : 0;
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        tick();
        tick();
        checks++;
        if (env_level !== 8'h00) begin
            failures++; $display("FAIL reset_env_level got=%h exp=00", env_level);
        end
        checks++;
        if (active !== 1'b0) begin
            failures++; $display("FAIL reset_active got=%b exp=0", active);
        end
        checks++;
        if (audio_out !== 14'h0) begin
            failures++; $display("FAIL reset_audio got=%h exp=0000", audio_out);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_attack();
        logic [7:0] e;
        logic [13:0] a;
        attack_rate = 8'hFF; decay_rate = 8'hFF;
        sustain_level = 8'h80; release_rate = 8'h80;
        gate = 1'b1;
        for (int i = 1; i <= 258; i++) begin
            osc_in = 14'($urandom);
            tick();
            e = m_env[15:8]; a = m_out[13:0];
            checks++;
            if (env_level !== e || active !== 1'b1 || audio_out !== a) begin
                failures++;
                $display("FAIL attack_step%0d got=%h/%b/%h exp=%h/1/%h", i, env_level, active, audio_out, e, a);
            end
            if (i == 1) begin
                checks++;
                if (env_level !== 8'h00) begin
                    failures++; $display("FAIL attack_entry got=%h exp=00", env_level);
                end
            end
        end
        checks++;
        if (env_level !== 8'hFF) begin
            failures++; $display("FAIL attack_peak got=%h exp=ff", env_level);
        end
    endtask

    task automatic test_decay_sustain();
        logic [7:0] e;
        for (int i = 1; i <= 129; i++) begin
            tick();
            e = m_env[15:8];
            checks++;
            if (env_level !== e) begin
                failures++; $display("FAIL decay_step%0d got=%h exp=%h", i, env_level, e);
            end
        end
        checks++;
        if (env_level !== 8'h80 || m_env != 'h8000) begin
            failures++; $display("FAIL sustain_reached got=%h exp=80", env_level);
        end
        sustain_level = 8'h40;
        tick();
        checks++;
        if (env_level !== 8'h40) begin
            failures++; $display("FAIL sustain_track got=%h exp=40", env_level);
        end
        sustain_level = 8'h80;
        tick();
        checks++;
        if (env_level !== 8'h80) begin
            failures++; $display("FAIL sustain_restore got=%h exp=80", env_level);
        end
    endtask

    task automatic test_vca_gain();
        osc_in = 14'h3FFF;
        tick();
        tick();
        checks++;
        if (audio_out !== 14'h0FFF) begin
            failures++; $display("FAIL vca_pos got=%h exp=0fff", audio_out);
        end
        osc_in = 14'h0000;
        tick();
        tick();
        checks++;
        if (audio_out !== 14'h3000) begin
            failures++; $display("FAIL vca_neg got=%h exp=3000", audio_out);
        end
    endtask

    task automatic test_release();
        logic [7:0] e;
        gate = 1'b0; release_rate = 8'h80;
        for (int i = 1; i <= 256; i++) begin
            tick();
            e = m_env[15:8];
            checks++;
            if (env_level !== e || active !== (m_phase != PH_IDLE)) begin
                failures++; $display("FAIL release_step%0d got=%h/%b exp=%h", i, env_level, active, e);
            end
            if (i == 255) begin
                checks++;
                if (active !== 1'b1) begin
                    failures++; $display("FAIL release_tail got=%b exp=1", active);
                end
            end
        end
        checks++;
        if (active !== 1'b0 || env_level !== 8'h00) begin
            failures++; $display("FAIL release_end got=%b/%h exp=0/00", active, env_level);
        end
    endtask

    task automatic test_vca_zero();
        osc_in = 14'h3FFF;
        tick();
        tick();
        checks++;
        if (audio_out !== 14'h0000) begin
            failures++; $display("FAIL vca_zero_gain got=%h exp=0000", audio_out);
        end
    endtask

    task automatic test_retrigger();
        int n;
        attack_rate = 8'hFF; decay_rate = 8'hFF;
        sustain_level = 8'h30; release_rate = 8'h00;
        gate = 1'b1;
        n = 0;
        while (m_phase != PH_SUS && n < 1000) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 1000 || env_level !== 8'h30) begin
            failures++; $display("FAIL retrig_setup got=%h exp=30 cycles=%0d", env_level, n);
        end
        gate = 1'b0;
        tick();
        tick();
        checks++;
        if (env_level !== 8'h30 || active !== 1'b1) begin
            failures++; $display("FAIL retrig_release_hold got=%h/%b exp=30/1", env_level, active);
        end
        gate = 1'b1;
        tick();
        checks++;
        if (env_level !== 8'h30 || active !== 1'b1) begin
            failures++; $display("FAIL retrig_no_drop got=%h/%b exp=30/1", env_level, active);
        end
        for (int i = 0; i < 17; i++) tick();
        checks++;
        if (env_level !== 8'h40) begin
            failures++; $display("FAIL retrig_continue got=%h exp=40", env_level);
        end
    endtask

    task automatic test_async_reset();
        int n;
        sustain_level = 8'h80; decay_rate = 8'hFF;
        n = 0;
        while (m_phase != PH_SUS && n < 1000) begin
            tick();
            n++;
        end
        osc_in = 14'h3FFF;
        tick();
        tick();
        checks++;
        if (env_level !== 8'h80 || active !== 1'b1 || audio_out !== 14'h0FFF) begin
            failures++; $display("FAIL areset_setup got=%h/%b/%h exp=80/1/0fff", env_level, active, audio_out);
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (env_level !== 8'h00 || active !== 1'b0 || audio_out !== 14'h0) begin
            failures++; $display("FAIL areset_async got=%h/%b/%h exp=00/0/0000", env_level, active, audio_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++;
        if (env_level !== 8'h00 || active !== (m_phase != PH_IDLE)) begin
            failures++; $display("FAIL areset_resume got=%h/%b exp=00/%0d", env_level, active, m_phase != PH_IDLE);
        end
    endtask

    task automatic test_random();
        logic [7:0] e;
        logic [13:0] a;
        logic act;
        for (int i = 0; i < 3000; i++) begin
            if (i % 64 == 0) begin
                attack_rate   = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
                decay_rate    = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
                release_rate  = 8'($urandom);
                sustain_level = 8'($urandom);
            end
            if ($urandom_range(0, 149) == 0) gate = ~gate;
            if ($urandom_range(0, 299) == 0) gate = 1'b0;
            osc_in = 14'($urandom);
            if (i == 1500) begin
                #2;
                rst_n = 1'b0;
                model_reset();
                @(negedge clk);
                rst_n = 1'b1;
            end
            tick();
            e = m_env[15:8]; a = m_out[13:0]; act = (m_phase != PH_IDLE);
            checks++;
            if (env_level !== e || active !== act || audio_out !== a) begin
                failures++;
                $display("FAIL random_cyc%0d got=%h/%b/%h exp=%h/%b/%h", i, env_level, active, audio_out, e, act, a);
            end
        end
    endtask

    initial begin
        test_reset();
        test_attack();
        test_decay_sustain();
        test_vca_gain();
        test_release();
        test_vca_zero();
        test_retrigger();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
